// File: rtl/regfile_sb.sv
// Parametrised register file with busy scoreboard and bulk-clear engine.
// Ports: clk/reset; write port (we, waddr, wdata); issue marking
// (issue, issue_addr); two combinational read ports (raddrN -> rdataN,
// rbusyN); clear handshake (clear_req -> clear_busy, clear_done).
module regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W:0]     w_cnt_nx;
    logic [WIDTH-1:0]    r_regs [DEPTH];
    logic [DEPTH-1:0]    r_busy;

    logic                w_idle;
    logic                w_wr_ok;
    logic                w_iss_ok;
    logic [ADDR_W-1:0]   w_clr_idx;
    logic [ADDR_W-1:0]   w_raddr [2];
    logic [WIDTH-1:0]    w_rdata [2];
    logic                w_rbusy [2];

    assign w_idle    = (r_state == S_IDLE);
    assign w_clr_idx = r_cnt[ADDR_W-1:0];

    // Writes and issues to reg 0 are discarded when it is hardwired.
    assign w_wr_ok  = we && w_idle
                   && !(ZERO_REG && waddr == '0);
    assign w_iss_ok = issue && w_idle
                   && !(ZERO_REG && issue_addr == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        clear_busy = 1'b0;
        clear_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (clear_req) begin
                    w_state_nx = S_CLEAR;
                    w_cnt_nx   = '0;
                end
            end
            S_CLEAR: begin
                clear_busy = 1'b1;
                w_cnt_nx   = r_cnt + 1'b1;
                if (r_cnt == (ADDR_W+1)'(DEPTH - 1)) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                clear_busy = 1'b1;
                clear_done = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Issue is applied after the write so a same-edge pair leaves
    // the register busy: the newly issued op is still outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else if (r_state == S_CLEAR) begin
            r_regs[w_clr_idx] <= '0;
            r_busy[w_clr_idx] <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_regs[waddr] <= wdata;
                r_busy[waddr] <= 1'b0;
            end
            if (w_iss_ok) begin
                r_busy[issue_addr] <= 1'b1;
            end
        end
    end

    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = r_regs[w_raddr[p]];
            w_rbusy[p] = r_busy[w_raddr[p]];
            if (ZERO_REG && w_raddr[p] == '0) begin
                w_rdata[p] = '0;
                w_rbusy[p] = 1'b0;
            end else if (BYPASS && w_wr_ok
                         && waddr == w_raddr[p]) begin
                w_rdata[p] = wdata;
                // A same-cycle issue keeps the pre-edge busy view.
                if (!(w_iss_ok && issue_addr == w_raddr[p])) begin
                    w_rbusy[p] = 1'b0;
                end
            end
        end
    end

    assign rdata1 = w_rdata[0];
    assign rdata2 = w_rdata[1];
    assign rbusy1 = w_rbusy[0];
    assign rbusy2 = w_rbusy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb: default build (BYPASS=1)
// alongside a ZERO_REG=1, BYPASS=0 build sharing the same inputs.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        issue;
    logic [2:0]  issue_addr;
    logic [2:0]  raddr1;
    logic [2:0]  raddr2;
    logic        clear_req;

    logic [15:0] rdata1, rdata2, rdata1_z, rdata2_z;
    logic        rbusy1, rbusy2, rbusy1_z, rbusy2_z;
    logic        clear_busy, clear_done;
    logic        clear_busy_z, clear_done_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .reset(reset),
        .we(we), .waddr(waddr), .wdata(wdata),
        .issue(issue), .issue_addr(issue_addr),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .clear_req(clear_req),
        .clear_busy(clear_busy), .clear_done(clear_done)
    );

    regfile_sb #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut_z (
        .clk(clk), .reset(reset),
        .we(we), .waddr(waddr), .wdata(wdata),
        .issue(issue), .issue_addr(issue_addr),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_z), .rdata2(rdata2_z),
        .rbusy1(rbusy1_z), .rbusy2(rbusy2_z),
        .clear_req(clear_req),
        .clear_busy(clear_busy_z), .clear_done(clear_done_z)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        we = 1'b0; waddr = '0; wdata = '0;
        issue = 1'b0; issue_addr = '0;
        raddr1 = '0; raddr2 = '0; clear_req = 1'b0;
        step();
        step();
        chk("rst_rdata1", {16'h0, rdata1}, 32'h0);
        chk("rst_rbusy1", {31'h0, rbusy1}, 32'h0);
        chk("rst_cbusy", {31'h0, clear_busy}, 32'h0);
        chk("rst_cdone", {31'h0, clear_done}, 32'h0);
        reset = 1'b0;
        step();

        // Basic write then read.
        we = 1'b1; waddr = 3'd5; wdata = 16'hBEEF;
        step();
        we = 1'b0; raddr1 = 3'd5; raddr2 = 3'd4;
        #2;
        chk("wr5_data", {16'h0, rdata1}, 32'hBEEF);
        chk("wr5_busy", {31'h0, rbusy1}, 32'h0);
        chk("rd4_zero", {16'h0, rdata2}, 32'h0);
        chk("wr5_data_z", {16'h0, rdata1_z}, 32'hBEEF);

        // Same-cycle bypass.
        we = 1'b1; waddr = 3'd3; wdata = 16'h1234; raddr2 = 3'd3;
        #2;
        chk("byp_data", {16'h0, rdata2}, 32'h1234);
        chk("byp_busy", {31'h0, rbusy2}, 32'h0);
        chk("nobyp_data", {16'h0, rdata2_z}, 32'h0);
        step();
        we = 1'b0;
        chk("wr3_data_z", {16'h0, rdata2_z}, 32'h1234);

        // Issue reg2, busy for 3 cycles, then writeback clears it.
        issue = 1'b1; issue_addr = 3'd2; raddr1 = 3'd2;
        step();
        issue = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("iss_busy%0d", i), {31'h0, rbusy1}, 32'h1);
            step();
        end
        we = 1'b1; waddr = 3'd2; wdata = 16'h00AA;
        #2;
        chk("wb_byp_data", {16'h0, rdata1}, 32'h00AA);
        chk("wb_byp_busy", {31'h0, rbusy1}, 32'h0);
        chk("wb_nobyp_busy", {31'h0, rbusy1_z}, 32'h1);
        step();
        we = 1'b0;
        #2;
        chk("wb_data", {16'h0, rdata1}, 32'h00AA);
        chk("wb_busy", {31'h0, rbusy1}, 32'h0);
        chk("wb_busy_z", {31'h0, rbusy1_z}, 32'h0);

        // Same-edge issue and write: data stored, busy stays 1.
        we = 1'b1; waddr = 3'd2; wdata = 16'h0055;
        issue = 1'b1; issue_addr = 3'd2;
        #2;
        chk("iw_pre_data", {16'h0, rdata1}, 32'h0055);
        chk("iw_pre_busy", {31'h0, rbusy1}, 32'h0);
        step();
        we = 1'b0; issue = 1'b0;
        #2;
        chk("iw_data", {16'h0, rdata1}, 32'h0055);
        chk("iw_busy", {31'h0, rbusy1}, 32'h1);

        // Reg 0 hardwired in dut_z, ordinary in dut.
        we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF;
        issue = 1'b1; issue_addr = 3'd0; raddr1 = 3'd0;
        #2;
        chk("z0_pre_data", {16'h0, rdata1_z}, 32'h0);
        step();
        we = 1'b0; issue = 1'b0;
        #2;
        chk("z0_data", {16'h0, rdata1_z}, 32'h0);
        chk("z0_busy", {31'h0, rbusy1_z}, 32'h0);
        chk("r0_data", {16'h0, rdata1}, 32'hFFFF);
        chk("r0_busy", {31'h0, rbusy1}, 32'h1);

        // Fill all registers nonzero and busy.
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = 16'h1001 + 16'(i);
            issue = 1'b1; issue_addr = 3'(i);
            step();
        end
        we = 1'b0; issue = 1'b0;
        raddr1 = 3'd7; raddr2 = 3'd7;
        #2;
        chk("fill7_data", {16'h0, rdata1}, 32'h1008);
        chk("fill7_busy", {31'h0, rbusy1}, 32'h1);

        // Bulk clear: 8 CLEAR cycles, then one DONE cycle.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) begin
                we = 1'b1; waddr = 3'd7; wdata = 16'h7777;
                raddr1 = 3'd0;
            end
            #2;
            chk($sformatf("clr_busy_c%0d", c),
                {31'h0, clear_busy}, 32'h1);
            chk($sformatf("clr_done_c%0d", c),
                {31'h0, clear_done}, 32'h0);
            if (c == 3) begin
                chk("clr_nobyp", {16'h0, rdata2}, 32'h1008);
                chk("clr_r0", {16'h0, rdata1}, 32'h0);
            end
            if (c == 4) begin
                chk("clr_drop7", {16'h0, rdata2}, 32'h1008);
                chk("clr_busy7", {31'h0, rbusy2}, 32'h1);
            end
            step();
            we = 1'b0;
        end
        #2;
        chk("done_busy", {31'h0, clear_busy}, 32'h1);
        chk("done_pulse", {31'h0, clear_done}, 32'h1);
        chk("done_pulse_z", {31'h0, clear_done_z}, 32'h1);
        step();
        chk("post_busy", {31'h0, clear_busy}, 32'h0);
        chk("post_done", {31'h0, clear_done}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            raddr1 = 3'(i);
            #1;
            chk($sformatf("post_r%0d", i), {16'h0, rdata1}, 32'h0);
            chk($sformatf("post_b%0d", i), {31'h0, rbusy1}, 32'h0);
        end

        // Async reset in the 4th CLEAR cycle aborts the clear.
        we = 1'b1; waddr = 3'd7; wdata = 16'h4444;
        step();
        we = 1'b0; raddr1 = 3'd7;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        step();
        step();
        #2;
        chk("pre_rst_busy", {31'h0, clear_busy}, 32'h1);
        chk("pre_rst_r7", {16'h0, rdata1}, 32'h4444);
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'h0, clear_busy}, 32'h0);
        chk("arst_done", {31'h0, clear_done}, 32'h0);
        chk("arst_r7", {16'h0, rdata1}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("arst_nodone%0d", i),
                {31'h0, clear_done}, 32'h0);
        end
        #2;
        reset = 1'b0;
        step();
        we = 1'b1; waddr = 3'd6; wdata = 16'h0ABC; raddr1 = 3'd6;
        step();
        we = 1'b0;
        #2;
        chk("after_rst_wr", {16'h0, rdata1}, 32'h0ABC);
        chk("after_rst_idle", {31'h0, clear_busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 8x16 general-purpose register file, for the pipelined datapath.
- Generalised depth and width, with an optional hardwired zero register and optional write-to-read bypass.
- Adds a per-register busy scoreboard for multi-cycle operations and a sequential bulk-clear engine.
- Sits between decode (read addresses, issue marking) and writeback (write port).

Parameters:
- WIDTH, 16, data width of each register in bits.
- DEPTH, 8, number of registers; must be a power of 2 and at least 2. ADDR_W = $clog2(DEPTH) is a localparam.
- ZERO_REG, 0, when 1 register 0 always reads as zero, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  writeback write enable.
- waddr  in  ADDR_W  writeback destination register.
- wdata  in  WIDTH  writeback data.
- issue  in  1  mark a register busy (a multi-cycle op has been issued to it).
- issue_addr  in  ADDR_W  register to mark busy.
- raddr1  in  ADDR_W  read port 1 address.
- raddr2  in  ADDR_W  read port 2 address.
- rdata1  out  WIDTH  read port 1 data, combinational.
- rdata2  out  WIDTH  read port 2 data, combinational.
- rbusy1  out  1  busy flag for raddr1, combinational.
- rbusy2  out  1  busy flag for raddr2, combinational.
- clear_req  in  1  request a bulk clear of all registers.
- clear_busy  out  1  clear sequence in progress.
- clear_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (async, active-high), effective immediately and held while high:
  - all registers = 0, all busy bits = 0;
  - FSM = IDLE, clear counter = 0;
  - clear_busy = 0, clear_done = 0.
  - Reset asserted mid-clear aborts the clear; no clear_done pulse is generated.
- Write:
  - on the clk edge with we=1 and FSM=IDLE, reg[waddr] <= wdata and busy[waddr] <= 0.
  - Write to reg 0 is dropped when ZERO_REG=1.
- Issue:
  - on the clk edge with issue=1 and FSM=IDLE, busy[issue_addr] <= 1.
  - Ignored for reg 0 when ZERO_REG=1.
- Same-edge issue and write to the same address: the write data is stored and busy ends at 1 (issue wins, because a new op is pending).
- Reads (each port independent, no latency):
  - rdata = reg[raddr], rbusy = busy[raddr].
  - ZERO_REG=1 and raddr=0: rdata = 0, rbusy = 0.
  - BYPASS=1, we=1, FSM=IDLE and waddr==raddr (and not the zero reg): rdata = wdata and rbusy = 0, unless issue targets the same address that cycle, in which case rbusy = busy[raddr].
  - BYPASS=0: reads return pre-edge register contents.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR when clear_req=1 at the edge; counter <= 0.
  - CLEAR: each cycle reg[counter] <= 0, busy[counter] <= 0, counter++. After processing index DEPTH-1 -> DONE.
  - DONE: clear_done = 1 for exactly one cycle -> IDLE.
  - clear_busy = 1 in CLEAR and DONE. CLEAR lasts exactly DEPTH cycles.
  - clear_req is ignored outside IDLE and is not queued.
  - If clear_req is still high on return to IDLE, a new clear starts.
  - In CLEAR and DONE, we and issue are dropped (no state change) and bypass is disabled. Callers must hold a write until clear_busy = 0.
  - Reads during CLEAR return current contents: already-cleared entries read 0, the rest are unchanged.
- If clear_req and we are both asserted on the same IDLE edge, the write is performed first, then the FSM enters CLEAR; the register is cleared when its index comes up.
- Width rules:
  - Addresses are exactly ADDR_W bits, so out-of-range addresses are impossible.
  - The clear counter is ADDR_W+1 bits wide so the terminal compare is unambiguous.

Test Plan:
- Reset, then write reg5=16'hBEEF, read raddr1=5 the next cycle -> rdata1=16'hBEEF, rbusy1=0. Other registers read 16'h0000.
- BYPASS=1: we=1, waddr=3, wdata=16'h1234 with raddr2=3 in the same cycle -> rdata2=16'h1234 before the edge. BYPASS=0 -> 16'h0000.
- issue reg2, then 3 cycles later write reg2=16'h00AA -> rbusy=1 for those 3 cycles, then 0 with data 16'h00AA. Same-edge issue and write to reg2 -> busy stays 1.
- ZERO_REG=1: write reg0=16'hFFFF and issue reg0 -> rdata=0, rbusy=0.
- Fill all 8 registers with nonzero values and mark all busy, pulse clear_req -> clear_busy high for 8 cycles, clear_done pulses on cycle 9. During the clear, a write to reg7 is dropped. Afterwards all registers are 0 and not busy.
- Assert reset asynchronously, between edges, on the 4th cycle of CLEAR -> outputs go to reset values immediately, with no clear_done. After reset release, the FSM is IDLE and a normal write succeeds.
